// File: rtl/fu_mul_issue.sv
// rtl/fu_mul_issue.sv - single-slot issue/writeback sequencer for a fixed-latency multiplier
module fu_mul_issue #(
  parameter int LATENCY = 7,
  parameter int TAG_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [31:0]      issue_a,
  input  logic [31:0]      issue_b,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic             flush,
  output logic             fu_en,
  output logic [31:0]      fu_a,
  output logic [31:0]      fu_b,
  input  logic [31:0]      fu_res,
  output logic             wb_valid,
  output logic [31:0]      wb_data,
  output logic [TAG_W-1:0] wb_tag,
  input  logic             wb_ack,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISP,
    S_EXEC,
    S_WB,
    S_DRAIN
  } state_t;

  localparam logic [6:0] LAT = 7'(LATENCY);

  state_t           state_q, state_d;
  logic [6:0]       cnt_q, cnt_d;
  logic [TAG_W-1:0] tag_q;
  logic             accept;
  logic             capture;

  assign issue_ready = (state_q == S_IDLE) & ~flush & ~rst;
  assign accept      = issue_valid & issue_ready;
  assign fu_en       = (state_q == S_DISP);
  assign wb_valid    = (state_q == S_WB);
  assign busy        = (state_q != S_IDLE);
  assign wb_tag      = tag_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_DISP;
      end
      S_DISP: begin
        cnt_d   = LAT;
        state_d = flush ? S_DRAIN : S_EXEC;
      end
      S_EXEC: begin
        cnt_d = cnt_q - 7'd1;
        // A flush landing on the completion edge simply ends the drain there.
        if (cnt_q == 7'd1) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WB;
            capture = 1'b1;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q - 7'd1;
        if (cnt_q == 7'd1) state_d = S_IDLE;
      end
      S_WB: begin
        if (wb_ack | flush) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 7'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 7'd0;
      fu_a    <= 32'd0;
      fu_b    <= 32'd0;
      tag_q   <= '0;
      wb_data <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        fu_a  <= issue_a;
        fu_b  <= issue_b;
        tag_q <= issue_tag;
      end
      if (capture) wb_data <= fu_res;
    end
  end

endmodule

// File: tb/tb_fu_mul_issue.sv
// tb/tb_fu_mul_issue.sv - scoreboard bench for fu_mul_issue at LATENCY 4, 1 and 127
module tb_fu_mul_issue;

  localparam int LATS [3] = '{4, 1, 127};

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  iv, ir, fl, fe, wv, ack, bz;
  logic [31:0] ia [3];
  logic [31:0] ib [3];
  logic [31:0] fa [3];
  logic [31:0] fb [3];
  logic [31:0] fr [3];
  logic [31:0] wd [3];
  logic [2:0]  it [3];
  logic [2:0]  wt [3];

  logic [31:0] prod [3];
  logic [7:0]  rem  [3];

  logic [34:0] sb [$];
  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fu_mul_issue #(.LATENCY(4), .TAG_W(3)) u_l4 (
    .clk(clk), .rst(rst), .issue_valid(iv[0]), .issue_ready(ir[0]), .issue_a(ia[0]),
    .issue_b(ib[0]), .issue_tag(it[0]), .flush(fl[0]), .fu_en(fe[0]), .fu_a(fa[0]),
    .fu_b(fb[0]), .fu_res(fr[0]), .wb_valid(wv[0]), .wb_data(wd[0]), .wb_tag(wt[0]),
    .wb_ack(ack[0]), .busy(bz[0])
  );

  fu_mul_issue #(.LATENCY(1), .TAG_W(3)) u_l1 (
    .clk(clk), .rst(rst), .issue_valid(iv[1]), .issue_ready(ir[1]), .issue_a(ia[1]),
    .issue_b(ib[1]), .issue_tag(it[1]), .flush(fl[1]), .fu_en(fe[1]), .fu_a(fa[1]),
    .fu_b(fb[1]), .fu_res(fr[1]), .wb_valid(wv[1]), .wb_data(wd[1]), .wb_tag(wt[1]),
    .wb_ack(ack[1]), .busy(bz[1])
  );

  fu_mul_issue #(.LATENCY(127), .TAG_W(3)) u_l127 (
    .clk(clk), .rst(rst), .issue_valid(iv[2]), .issue_ready(ir[2]), .issue_a(ia[2]),
    .issue_b(ib[2]), .issue_tag(it[2]), .flush(fl[2]), .fu_en(fe[2]), .fu_a(fa[2]),
    .fu_b(fb[2]), .fu_res(fr[2]), .wb_valid(wv[2]), .wb_data(wd[2]), .wb_tag(wt[2]),
    .wb_ack(ack[2]), .busy(bz[2])
  );

  // Multiplier model: result is only valid on the cycle just before the edge that should capture it.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        rem[i] <= 8'd0;
      end else if (fe[i]) begin
        prod[i] <= fa[i] * fb[i];
        rem[i]  <= 8'(LATS[i]);
      end else if (rem[i] != 8'd0) begin
        rem[i] <= rem[i] - 8'd1;
      end
    end
  end

  assign fr[0] = (rem[0] == 8'd1) ? prod[0] : 32'hDEAD_BEEF;
  assign fr[1] = (rem[1] == 8'd1) ? prod[1] : 32'hDEAD_BEEF;
  assign fr[2] = (rem[2] == 8'd1) ? prod[2] : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one op on lane i; returns just after the edge following the accept edge (DISP -> EXEC).
  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] tag, input bit expect_wb);
    logic [31:0] p;
    iv[i] = 1'b1; ia[i] = a; ib[i] = b; it[i] = tag;
    @(negedge clk);
    check("issue_ready", ir[i], 1'b1);
    step();
    iv[i] = 1'b0;
    p = a * b;
    if (expect_wb) sb.push_back({tag, p});
    @(negedge clk);
    check("fu_en_disp", fe[i], 1'b1);
    check("fu_a", fa[i], a);
    check("fu_b", fb[i], b);
    step();
  endtask

  task automatic wait_wb(input int i, input int exp_edges);
    int n;
    bit seen;
    logic [34:0] e;
    n = 1;
    seen = 1'b0;
    while (!seen && n < 400) begin
      @(negedge clk);
      if (wv[i]) begin
        seen = 1'b1;
      end else begin
        check("fu_en_exec", fe[i], 1'b0);
        step();
        n++;
      end
    end
    check("wb_latency", n, seen ? exp_edges : -1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 1'b0, 1'b1);
    end else begin
      e = sb.pop_front();
      check("wb_data", wd[i], e[31:0]);
      check("wb_tag", wt[i], e[34:32]);
    end
    step();
  endtask

  task automatic watch_no_wb(input int i, input int cycles, input string tag);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (wv[i]) hit = 1'b1;
      step();
    end
    check(tag, hit, 1'b0);
  endtask

  task automatic reset_outputs(input int i, input string tag);
    check({tag, "_wv"}, wv[i], 1'b0);
    check({tag, "_busy"}, bz[i], 1'b0);
    check({tag, "_fe"}, fe[i], 1'b0);
    check({tag, "_ready"}, ir[i], 1'b0);
    check({tag, "_fab"}, {fa[i], fb[i]}, 64'd0);
    check({tag, "_wd"}, wd[i], 32'd0);
    check({tag, "_wt"}, wt[i], 3'd0);
  endtask

  initial begin
    rst = 1'b1; iv = '0; fl = '0; ack = '0;
    for (int i = 0; i < 3; i++) begin
      ia[i] = '0; ib[i] = '0; it[i] = '0;
    end
    step();
    step();
    @(negedge clk);
    reset_outputs(0, "rst0");
    step();
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", ir[0], 1'b1);
    step();

    // Basic op and latency 1+LATENCY
    issue(0, 32'd3, 32'd5, 3'd2, 1'b1);
    wait_wb(0, 5);

    // Held writeback stays stable without ack
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("hold_wv", wv[0], 1'b1);
      check("hold_wd", wd[0], 32'd15);
      check("hold_wt", wt[0], 3'd2);
      check("hold_ready", ir[0], 1'b0);
      step();
    end
    ack[0] = 1'b1;
    @(negedge clk);
    check("wv_before_ack_edge", wv[0], 1'b1);
    step();
    ack[0] = 1'b0;
    @(negedge clk);
    check("ack_wv", wv[0], 1'b0);
    check("ack_ready", ir[0], 1'b1);
    check("ack_busy", bz[0], 1'b0);
    step();

    // wb_ack while idle is ignored
    ack[0] = 1'b1;
    step();
    ack[0] = 1'b0;

    // Flush during EXEC with counter at 2
    issue(0, 32'd7, 32'd9, 3'd1, 1'b0);
    step();
    step();
    fl[0] = 1'b1;
    step();
    fl[0] = 1'b0;
    @(negedge clk);
    check("drain_busy", bz[0], 1'b1);
    check("drain_wv", wv[0], 1'b0);
    check("drain_ready", ir[0], 1'b0);
    step();
    @(negedge clk);
    check("drain_done_busy", bz[0], 1'b0);
    check("drain_done_ready", ir[0], 1'b1);
    watch_no_wb(0, 8, "flush_no_wb");

    // Flush beats issue_valid in IDLE
    iv[0] = 1'b1; fl[0] = 1'b1; ia[0] = 32'd4; ib[0] = 32'd4; it[0] = 3'd7;
    @(negedge clk);
    check("flush_idle_ready", ir[0], 1'b0);
    step();
    iv[0] = 1'b0; fl[0] = 1'b0;
    @(negedge clk);
    check("flush_idle_fe", fe[0], 1'b0);
    check("flush_idle_busy", bz[0], 1'b0);
    step();

    // Flush and ack together in WB
    issue(0, 32'd6, 32'd7, 3'd3, 1'b1);
    wait_wb(0, 5);
    fl[0] = 1'b1; ack[0] = 1'b1;
    step();
    fl[0] = 1'b0; ack[0] = 1'b0;
    @(negedge clk);
    check("fa_wv", wv[0], 1'b0);
    check("fa_busy", bz[0], 1'b0);
    check("fa_ready", ir[0], 1'b1);
    step();
    @(negedge clk);
    check("fa_still_idle", bz[0], 1'b0);
    step();

    // Back-to-back: ack on edge N, issue accepted on edge N+1
    issue(0, 32'd100, 32'd3, 3'd4, 1'b1);
    wait_wb(0, 5);
    ack[0] = 1'b1;
    @(negedge clk);
    check("b2b_fe_wb", fe[0], 1'b0);
    step();
    ack[0] = 1'b0;
    issue(0, 32'hFFFF_FFFF, 32'd2, 3'd5, 1'b1);
    wait_wb(0, 5);
    ack[0] = 1'b1;
    step();
    ack[0] = 1'b0;

    // LATENCY=1 normal op
    issue(1, 32'd11, 32'd13, 3'd6, 1'b1);
    wait_wb(1, 2);
    ack[1] = 1'b1;
    step();
    ack[1] = 1'b0;

    // Reset in EXEC, LATENCY=1
    issue(1, 32'd2, 32'd3, 3'd1, 1'b0);
    rst = 1'b1;
    step();
    @(negedge clk);
    reset_outputs(1, "rst_l1");
    step();
    rst = 1'b0;
    watch_no_wb(1, 6, "rst_l1_no_wb");

    // Reset in EXEC, LATENCY=127
    issue(2, 32'd9, 32'd9, 3'd7, 1'b0);
    for (int k = 0; k < 10; k++) step();
    @(negedge clk);
    check("l127_busy", bz[2], 1'b1);
    rst = 1'b1;
    step();
    @(negedge clk);
    reset_outputs(2, "rst_l127");
    step();
    rst = 1'b0;
    watch_no_wb(2, 140, "rst_l127_no_wb");
    @(negedge clk);
    check("l127_idle", bz[2], 1'b0);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fu_mul_issue.md
FU_MUL_ISSUE -- requirements
Module: fu_mul_issue

Interface
REQ-001 Parameter LATENCY, default 7, meaning: cycles from the fu_en sampling edge to a valid fu_res; legal range 1..127.
REQ-002 Parameter TAG_W, default 3, meaning: width of the reservation-station tag carried with each operation.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 issue_valid  in  1  dispatch offers an operation this cycle.
REQ-006 issue_ready  out  1  unit accepts an operation this cycle.
REQ-007 issue_a, issue_b  in  32 each  operands.
REQ-008 issue_tag  in  TAG_W  destination tag.
REQ-009 flush  in  1  discard in-flight operation.
REQ-010 fu_en  out  1  start pulse to the multiplier unit.
REQ-011 fu_a, fu_b  out  32 each  operands to the multiplier unit.
REQ-012 fu_res  in  32  multiplier result.
REQ-013 wb_valid  out  1  result awaiting writeback.
REQ-014 wb_data  out  32  result; wb_tag  out  TAG_W  its tag.
REQ-015 wb_ack  in  1  writeback bus has taken the result.
REQ-016 busy  out  1  high whenever state is not IDLE.

Function
REQ-017 FSM states: IDLE, DISP, EXEC, WB, DRAIN; one operation in flight at most.
REQ-018 issue_ready SHALL equal (state==IDLE) & ~flush & ~rst.
REQ-019 On an edge with issue_valid & issue_ready: register issue_a/b into fu_a/b, issue_tag into tag register, go DISP.
REQ-020 fu_en SHALL be high for exactly the single DISP cycle, low in every other state; fu_a/fu_b hold their values until the next accept.
REQ-021 DISP -> EXEC unconditionally (absent flush), loading a 7-bit down-counter with LATENCY.
REQ-022 In EXEC the counter decrements each edge; on the edge where counter==1, capture fu_res into wb_data and go WB.
REQ-023 Total: wb_valid SHALL rise exactly 1+LATENCY edges after the accept edge.
REQ-024 In WB, wb_valid=1 and wb_data/wb_tag SHALL stay stable until wb_ack; on the edge with wb_ack, go IDLE and drop wb_valid.
REQ-025 wb_ack outside WB SHALL be ignored.
REQ-026 flush in IDLE: no effect except issue_ready=0 (flush beats issue_valid).
REQ-027 flush in DISP or EXEC: go DRAIN, keep counting (DISP loads LATENCY as normal); no capture, no writeback.
REQ-028 DRAIN: counter decrements; on counter==1 edge go IDLE without asserting wb_valid; flush in DRAIN has no further effect.
REQ-029 flush in WB: go IDLE, wb_valid low next cycle, result lost; flush with wb_ack same edge behaves identically (single return to IDLE).
REQ-030 LATENCY=1: EXEC lasts one cycle (counter loaded 1, captured on next edge).
REQ-031 wb_data SHALL be the low 32 bits of the product as delivered on fu_res; no width manipulation inside this block.

Reset
REQ-032 rst high at an edge: state IDLE, counter 0, fu_en 0, fu_a/fu_b 0, wb_valid 0, wb_data 0, wb_tag 0, busy 0; issue_ready 0 while rst high.
REQ-033 rst mid-operation (any state) SHALL abort with no writeback; bench FU model must also be reset or drained before next issue.

Verification
REQ-034 LATENCY=4, issue a=3 b=5 tag=2 at edge 0, FU model returns 15 -> fu_en high cycle 1 only with fu_a=3 fu_b=5; wb_valid rises after edge 5, wb_data=15, wb_tag=2.
REQ-035 Same op, wb_ack held low 10 cycles -> wb_valid/wb_data/wb_tag stable all 10 cycles, issue_ready 0; ack -> IDLE next edge, issue_ready 1.
REQ-036 flush during EXEC at counter=2 -> busy stays high until original completion edge, wb_valid never asserted, then issue_ready 1.
REQ-037 flush and issue_valid together in IDLE -> no accept, fu_en stays 0; flush and wb_ack together in WB -> single return to IDLE.
REQ-038 Back-to-back: ack on edge N, new issue a=0xFFFFFFFF b=2 on edge N+1 -> wb_data=0xFFFFFFFE, tag correct, no overlap of fu_en pulses.
REQ-039 rst asserted in EXEC with LATENCY=1 and LATENCY=127 -> all outputs reset values next cycle, no wb_valid pulse.
